// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the fetch-stage PC owner.
// Pure declarations; no timing and no flow control of its own.
package pc_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
  localparam logic [31:0] IM_LO_DEF      = 32'h0000_3000;
  localparam logic [31:0] IM_HI_DEF      = 32'h0000_6ffc;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_fetch_addr_chk.sv
// Fetch address legality check: alignment and instruction-memory window.
// Purely combinational on pc; no backpressure.
module fetch_addr_chk
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] IM_LO = IM_LO_DEF,
  parameter logic [31:0] IM_HI = IM_HI_DEF
) (
  input  logic [31:0] pc,
  output logic        if_adel,
  output logic [4:0]  if_excode
);

  logic misaligned;
  logic below_lo;
  logic above_hi;

  always_comb begin
    misaligned = |pc[1:0];
    below_lo   = pc < IM_LO;
    above_hi   = pc > IM_HI;
    if_adel    = misaligned | below_lo | above_hi;
    if_excode  = if_adel ? EXC_ADEL : EXC_NONE;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC owner: picks seq/redirect/stall/exception/eret each cycle and tags IF outputs.
// PC updates one cycle after the request; exception/eret insert exactly one bubble (REDIR).
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] IM_LO      = IM_LO_DEF,
  parameter logic [31:0] IM_HI      = IM_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        use_npc,
  input  logic [31:0] next_pc_in,
  input  logic        d_is_jb,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        if_valid,
  output logic        if_bd,
  output logic        if_adel,
  output logic [4:0]  if_excode
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         bd_q, bd_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bd_d    = bd_q;
    if (exc_req) begin
      pc_d    = EXC_VECTOR;
      bd_d    = 1'b0;
      state_d = ST_REDIR;
    end else if (eret_req) begin
      // eret has no delay slot, so the in-flight fetch is dropped via the bubble
      pc_d    = epc;
      bd_d    = 1'b0;
      state_d = ST_REDIR;
    end else if (state_q == ST_REDIR) begin
      state_d = ST_RUN;
    end else if (stall) begin
      pc_d = pc_q;
      bd_d = bd_q;
    end else if (use_npc) begin
      pc_d = next_pc_in;
      bd_d = d_is_jb;
    end else begin
      pc_d = pc_plus4(pc_q);
      bd_d = d_is_jb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      bd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
    end
  end

  always_comb begin
    pc       = pc_q;
    pc4      = pc_plus4(pc_q);
    if_valid = (state_q == ST_RUN);
    if_bd    = bd_q & if_valid;
  end

  fetch_addr_chk #(
    .IM_LO (IM_LO),
    .IM_HI (IM_HI)
  ) u_addr_chk (
    .pc        (pc_q),
    .if_adel   (if_adel),
    .if_excode (if_excode)
  );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: each stimulus row pushes the expected post-edge
// fetch tags; the scenario task pops and compares them one cycle later.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, use_npc, d_is_jb, exc_req, eret_req;
  logic [31:0] next_pc_in, epc;
  logic [31:0] pc, pc4;
  logic        if_valid, if_bd, if_adel;
  logic [4:0]  if_excode;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rst, stl, en;
    logic [31:0] npc;
    logic        jb, exc, eret;
    logic [31:0] epc_v;
    logic [31:0] e_pc;
    logic        e_v, e_bd, e_adel;
  } stim_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        v;
    logic        bd;
    logic        adel;
    logic [4:0]  xc;
  } obs_t;

  obs_t exp_q[$];

  pc_fetch_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .use_npc    (use_npc),
    .next_pc_in (next_pc_in),
    .d_is_jb    (d_is_jb),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .pc         (pc),
    .pc4        (pc4),
    .if_valid   (if_valid),
    .if_bd      (if_bd),
    .if_adel    (if_adel),
    .if_excode  (if_excode)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic rst, stl, en, input logic [31:0] npc,
                               input logic jb, exc, eret, input logic [31:0] ep,
                               input logic [31:0] e_pc, input logic e_v, e_bd, e_adel);
    stim_t s;
    s.rst = rst; s.stl = stl; s.en = en; s.npc = npc; s.jb = jb;
    s.exc = exc; s.eret = eret; s.epc_v = ep;
    s.e_pc = e_pc; s.e_v = e_v; s.e_bd = e_bd; s.e_adel = e_adel;
    return s;
  endfunction

  // Drive one cycle of inputs and queue what the outputs must show after the edge.
  task automatic apply(input stim_t s);
    obs_t w;
    reset = s.rst; stall = s.stl; use_npc = s.en; next_pc_in = s.npc;
    d_is_jb = s.jb; exc_req = s.exc; eret_req = s.eret; epc = s.epc_v;
    w.pc = s.e_pc; w.pc4 = s.e_pc + 32'd4; w.v = s.e_v; w.bd = s.e_bd;
    w.adel = s.e_adel; w.xc = s.e_adel ? 5'd4 : 5'd0;
    exp_q.push_back(w);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t t[$];
    obs_t got, want;
    t.push_back(mk(1,0,0,0,0,0,0,0, 32'h3000,1,0,0));
    t.push_back(mk(1,0,0,0,0,0,0,0, 32'h3000,1,0,0));
    t.push_back(mk(0,0,0,0,0,0,0,0, 32'h3004,1,0,0));
    t.push_back(mk(0,0,0,0,0,0,0,0, 32'h3008,1,0,0));
    t.push_back(mk(0,0,0,0,0,0,0,0, 32'h300c,1,0,0));
    t.push_back(mk(0,0,0,0,0,0,0,0, 32'h3010,1,0,0));
    foreach (t[i]) begin
      apply(t[i]);
      got = {pc, pc4, if_valid, if_bd, if_adel, if_excode};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset[%0d] got pc=%h pc4=%h v=%b bd=%b adel=%b xc=%0d want pc=%h pc4=%h v=%b bd=%b adel=%b xc=%0d",
                 i, got.pc, got.pc4, got.v, got.bd, got.adel, got.xc, want.pc, want.pc4, want.v, want.bd, want.adel, want.xc);
      end
    end
  endtask

  task automatic test_redirect();
    stim_t t[$];
    obs_t got, want;
    t.push_back(mk(0,0,1,32'h3040,1,0,0,0, 32'h3040,1,1,0));
    t.push_back(mk(0,0,0,0,       0,0,0,0, 32'h3044,1,0,0));
    t.push_back(mk(0,0,1,32'h3020,0,0,0,0, 32'h3020,1,0,0));
    foreach (t[i]) begin
      apply(t[i]);
      got = {pc, pc4, if_valid, if_bd, if_adel, if_excode};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL redirect[%0d] got pc=%h pc4=%h v=%b bd=%b adel=%b xc=%0d want pc=%h pc4=%h v=%b bd=%b adel=%b xc=%0d",
                 i, got.pc, got.pc4, got.v, got.bd, got.adel, got.xc, want.pc, want.pc4, want.v, want.bd, want.adel, want.xc);
      end
    end
  endtask

  task automatic test_stall();
    stim_t t[$];
    obs_t got, want;
    for (int k = 0; k < 3; k++) t.push_back(mk(0,1,1,32'h3080,1,0,0,0, 32'h3020,1,0,0));
    t.push_back(mk(0,0,1,32'h3080,1,0,0,0, 32'h3080,1,1,0));
    t.push_back(mk(0,0,1,32'h3100,0,0,0,0, 32'h3100,1,0,0));
    foreach (t[i]) begin
      apply(t[i]);
      got = {pc, pc4, if_valid, if_bd, if_adel, if_excode};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL stall[%0d] got pc=%h pc4=%h v=%b bd=%b adel=%b xc=%0d want pc=%h pc4=%h v=%b bd=%b adel=%b xc=%0d",
                 i, got.pc, got.pc4, got.v, got.bd, got.adel, got.xc, want.pc, want.pc4, want.v, want.bd, want.adel, want.xc);
      end
    end
  endtask

  task automatic test_exception();
    stim_t t[$];
    obs_t got, want;
    t.push_back(mk(0,1,1,32'h3200,1,1,0,0, 32'h4180,0,0,0));
    t.push_back(mk(0,1,1,32'h3200,1,0,0,0, 32'h4180,1,0,0));
    t.push_back(mk(0,0,0,0,       0,0,0,0, 32'h4184,1,0,0));
    t.push_back(mk(0,0,1,32'h3300,1,0,0,0, 32'h3300,1,1,0));
    t.push_back(mk(0,0,0,0,       0,1,0,0, 32'h4180,0,0,0));
    t.push_back(mk(0,0,0,0,       0,0,0,0, 32'h4180,1,0,0));
    foreach (t[i]) begin
      apply(t[i]);
      got = {pc, pc4, if_valid, if_bd, if_adel, if_excode};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL exception[%0d] got pc=%h pc4=%h v=%b bd=%b adel=%b xc=%0d want pc=%h pc4=%h v=%b bd=%b adel=%b xc=%0d",
                 i, got.pc, got.pc4, got.v, got.bd, got.adel, got.xc, want.pc, want.pc4, want.v, want.bd, want.adel, want.xc);
      end
    end
  endtask

  task automatic test_eret();
    stim_t t[$];
    obs_t got, want;
    t.push_back(mk(0,0,0,0,       0,0,1,32'h3204, 32'h3204,0,0,0));
    t.push_back(mk(0,0,0,0,       0,0,0,0,        32'h3204,1,0,0));
    t.push_back(mk(0,0,0,0,       0,0,0,0,        32'h3208,1,0,0));
    t.push_back(mk(0,0,1,32'h3300,1,0,0,0,        32'h3300,1,1,0));
    t.push_back(mk(0,0,0,0,       1,0,1,32'h3400, 32'h3400,0,0,0));
    t.push_back(mk(0,0,0,0,       0,1,1,32'h3400, 32'h4180,0,0,0));
    t.push_back(mk(0,0,0,0,       0,1,0,0,        32'h4180,0,0,0));
    t.push_back(mk(0,0,0,0,       0,0,0,0,        32'h4180,1,0,0));
    t.push_back(mk(0,0,0,0,       0,1,1,32'h3204, 32'h4180,0,0,0));
    t.push_back(mk(0,0,0,0,       0,0,0,0,        32'h4180,1,0,0));
    t.push_back(mk(0,0,0,0,       0,0,1,32'h3204, 32'h3204,0,0,0));
    t.push_back(mk(0,0,0,0,       0,0,1,32'h3208, 32'h3208,0,0,0));
    t.push_back(mk(0,0,0,0,       0,0,0,0,        32'h3208,1,0,0));
    foreach (t[i]) begin
      apply(t[i]);
      got = {pc, pc4, if_valid, if_bd, if_adel, if_excode};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL eret[%0d] got pc=%h pc4=%h v=%b bd=%b adel=%b xc=%0d want pc=%h pc4=%h v=%b bd=%b adel=%b xc=%0d",
                 i, got.pc, got.pc4, got.v, got.bd, got.adel, got.xc, want.pc, want.pc4, want.v, want.bd, want.adel, want.xc);
      end
    end
  endtask

  task automatic test_adel();
    stim_t t[$];
    obs_t got, want;
    t.push_back(mk(0,0,1,32'h3002,    0,0,0,0, 32'h3002,1,0,1));
    t.push_back(mk(0,0,1,32'h7000,    0,0,0,0, 32'h7000,1,0,1));
    t.push_back(mk(0,0,1,32'h6ffc,    0,0,0,0, 32'h6ffc,1,0,0));
    t.push_back(mk(0,0,0,0,           0,0,0,0, 32'h7000,1,0,1));
    t.push_back(mk(0,0,1,32'h2ffc,    0,0,0,0, 32'h2ffc,1,0,1));
    t.push_back(mk(0,0,1,32'h3000,    0,0,0,0, 32'h3000,1,0,0));
    t.push_back(mk(0,0,1,32'hffff_fffc,0,0,0,0, 32'hffff_fffc,1,0,1));
    t.push_back(mk(0,0,0,0,           0,0,0,0, 32'h0000_0000,1,0,1));
    t.push_back(mk(0,0,0,0,           0,0,1,32'h3001, 32'h3001,0,0,1));
    t.push_back(mk(0,0,0,0,           0,0,0,0, 32'h3001,1,0,1));
    t.push_back(mk(0,0,0,0,           0,0,0,0, 32'h3005,1,0,1));
    foreach (t[i]) begin
      apply(t[i]);
      got = {pc, pc4, if_valid, if_bd, if_adel, if_excode};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL adel[%0d] got pc=%h pc4=%h v=%b bd=%b adel=%b xc=%0d want pc=%h pc4=%h v=%b bd=%b adel=%b xc=%0d",
                 i, got.pc, got.pc4, got.v, got.bd, got.adel, got.xc, want.pc, want.pc4, want.v, want.bd, want.adel, want.xc);
      end
    end
  endtask

  task automatic test_reset_priority();
    stim_t t[$];
    obs_t got, want;
    t.push_back(mk(1,1,1,32'h3500,1,0,0,0, 32'h3000,1,0,0));
    t.push_back(mk(0,0,0,0,       0,1,0,0, 32'h4180,0,0,0));
    t.push_back(mk(1,0,0,0,       0,0,0,0, 32'h3000,1,0,0));
    t.push_back(mk(1,0,0,0,       0,1,1,32'h3204, 32'h3000,1,0,0));
    t.push_back(mk(0,0,0,0,       0,0,0,0, 32'h3004,1,0,0));
    foreach (t[i]) begin
      apply(t[i]);
      got = {pc, pc4, if_valid, if_bd, if_adel, if_excode};
      want = exp_q.pop_front();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_prio[%0d] got pc=%h pc4=%h v=%b bd=%b adel=%b xc=%0d want pc=%h pc4=%h v=%b bd=%b adel=%b xc=%0d",
                 i, got.pc, got.pc4, got.v, got.bd, got.adel, got.xc, want.pc, want.pc4, want.v, want.bd, want.adel, want.xc);
      end
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; use_npc = 1'b0; next_pc_in = '0;
    d_is_jb = 1'b0; exc_req = 1'b0; eret_req = 1'b0; epc = '0;
    #1;
    test_reset();
    test_redirect();
    test_stall();
    test_exception();
    test_eret();
    test_adel();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
